// File: rtl/pingpong_stream_buf_if.sv
// Producer/consumer signal bundle for the ping-pong stream buffer.
// master = producer/consumer side, slave = buffer side.
interface pingpong_stream_buf_if #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 16
);
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          wr_last;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_done;
  logic          bank_ready;
  logic          rd_bank;
  logic [AW:0]   rd_len;
  logic          overflow;
  logic [CW-1:0] drop_cnt;

  modport master (
    output wr_en, wr_data, wr_last, rd_en, rd_addr, rd_done,
    input  rd_data, rd_valid, bank_ready, rd_bank, rd_len, overflow, drop_cnt
  );

  modport slave (
    input  wr_en, wr_data, wr_last, rd_en, rd_addr, rd_done,
    output rd_data, rd_valid, bank_ready, rd_bank, rd_len, overflow, drop_cnt
  );
endinterface

// File: rtl/pingpong_stream_buf.sv
// Double-bank stream buffer: writer fills one bank while the reader drains the other,
// with early close, drop counting and a 1-cycle registered read port.
module pingpong_stream_buf #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 8,
  parameter int unsigned CW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  pingpong_stream_buf_if.slave bus
);
  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned LW    = AW + 1;

  logic [DW-1:0] mem_q [2*DEPTH];

  logic          wr_bank_q, wr_bank_d;
  logic [AW-1:0] wr_ptr_q,  wr_ptr_d;
  logic [1:0]    full_q,    full_d;
  logic [LW-1:0] len_q [2];
  logic [LW-1:0] len_d [2];
  logic          rd_bank_q, rd_bank_d;
  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic          overflow_q;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;

  logic          wr_ok_c, drop_c, close_c, rel_c, rd_ok_c;
  logic [LW-1:0] close_len_c;

  // Handshake qualification against the registered full flags
  always_comb begin
    wr_ok_c     = bus.wr_en && !full_q[wr_bank_q];
    drop_c      = bus.wr_en &&  full_q[wr_bank_q];
    rel_c       = bus.rd_done && full_q[rd_bank_q];
    rd_ok_c     = bus.rd_en   && full_q[rd_bank_q];
    // An idle wr_last only closes a bank that already holds data
    close_c     = (wr_ok_c && (bus.wr_last || (wr_ptr_q == AW'(DEPTH - 1)))) ||
                  (!bus.wr_en && bus.wr_last && (wr_ptr_q != '0));
    close_len_c = LW'(wr_ptr_q) + LW'(wr_ok_c);
  end

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_ptr_d   = wr_ptr_q;
    full_d     = full_q;
    len_d[0]   = len_q[0];
    len_d[1]   = len_q[1];
    rd_bank_d  = rd_bank_q;
    drop_cnt_d = drop_cnt_q;

    if (wr_ok_c) wr_ptr_d = wr_ptr_q + AW'(1);
    // Close and release always target different banks, so both may apply at once
    if (close_c) begin
      full_d[wr_bank_q] = 1'b1;
      len_d[wr_bank_q]  = close_len_c;
      wr_bank_d         = !wr_bank_q;
      wr_ptr_d          = '0;
    end
    if (rel_c) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = !rd_bank_q;
    end
    if (drop_c && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q  <= 1'b0;
      wr_ptr_q   <= '0;
      full_q     <= '0;
      len_q[0]   <= '0;
      len_q[1]   <= '0;
      rd_bank_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_ptr_q   <= wr_ptr_d;
      full_q     <= full_d;
      len_q[0]   <= len_d[0];
      len_q[1]   <= len_d[1];
      rd_bank_q  <= rd_bank_d;
      rd_valid_q <= rd_ok_c;
      if (rd_ok_c) rd_data_q <= mem_q[{rd_bank_q, bus.rd_addr}];
      if (drop_c)  overflow_q <= 1'b1;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) mem_q[{wr_bank_q, wr_ptr_q}] <= bus.wr_data;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.bank_ready = full_q[rd_bank_q];
  assign bus.rd_bank    = rd_bank_q;
  assign bus.rd_len     = len_q[rd_bank_q];
  assign bus.overflow   = overflow_q;
  assign bus.drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_pingpong_stream_buf.sv
// Self-checking bench for pingpong_stream_buf (AW=2) with a read-data scoreboard.
module tb_pingpong_stream_buf;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned CW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pingpong_stream_buf_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();
  pingpong_stream_buf_if #(.DW(DW), .AW(AW), .CW(2))  bus2 ();

  pingpong_stream_buf #(.DW(DW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave)
  );
  pingpong_stream_buf #(.DW(DW), .AW(AW), .CW(2)) dut_sat (
    .clk(clk), .rst(rst), .bus(bus2.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  // Scoreboard: every rd_valid pops the value queued when the read was issued
  always @(negedge clk) begin
    if (bus.rd_valid === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_unexpected: rd_valid=1 rd_data=%h, required no read", bus.rd_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if (bus.rd_data !== mon_exp) begin
          n_fail++;
          $display("FAIL rd_data: got %h, required %h", bus.rd_data, mon_exp);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic we, input logic [7:0] wd, input logic wl,
                     input logic re, input logic [1:0] ra, input logic rdn,
                     input logic exp_acc, input logic [7:0] ed);
    bus.wr_en = we; bus.wr_data = wd; bus.wr_last = wl;
    bus.rd_en = re; bus.rd_addr = ra; bus.rd_done = rdn;
    if (re && exp_acc) exp_q.push_back(ed);
    tick();
    bus.wr_en = 1'b0; bus.wr_last = 1'b0; bus.rd_en = 1'b0; bus.rd_done = 1'b0;
  endtask

  task automatic wr(input logic [7:0] d);
    cyc(1'b1, d, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic rd(input logic [1:0] a, input logic [7:0] e);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, a, 1'b0, 1'b1, e);
  endtask

  task automatic done();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic last_only();
    cyc(1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain_check(input string name);
    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d reads outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.bank_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b, required 0", bus.bank_ready); end
    n_checks++; if (bus.rd_len !== 3'd0) begin n_fail++; $display("FAIL reset_len: got %0d, required 0", bus.rd_len); end
    n_checks++; if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL reset_bank: got %b, required 0", bus.rd_bank); end
    n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", bus.rd_valid); end
    n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h, required 00", bus.rd_data); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b, required 0", bus.overflow); end
    n_checks++; if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d, required 0", bus.drop_cnt); end
  endtask

  task automatic test_fill_read();
    for (int i = 0; i < 4; i++) begin
      wr(8'(8'h10 + i));
      if (i == 2) begin
        n_checks++; if (bus.bank_ready !== 1'b0) begin n_fail++; $display("FAIL fill_early_ready: got %b, required 0", bus.bank_ready); end
      end
    end
    n_checks++; if (bus.bank_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready: got %b, required 1", bus.bank_ready); end
    n_checks++; if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL fill_bank: got %b, required 0", bus.rd_bank); end
    n_checks++; if (bus.rd_len !== 3'd4) begin n_fail++; $display("FAIL fill_len: got %0d, required 4", bus.rd_len); end
    for (int a = 0; a < 4; a++) rd(2'(a), 8'(8'h10 + a));
    drain_check("fill");
  endtask

  task automatic test_not_ready();
    done();
    n_checks++; if (bus.bank_ready !== 1'b0) begin n_fail++; $display("FAIL nr_ready: got %b, required 0", bus.bank_ready); end
    n_checks++; if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL nr_bank: got %b, required 1", bus.rd_bank); end
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h00);
    n_checks++; if (bus.rd_valid !== 1'b0) begin n_fail++; $display("FAIL nr_valid: got %b, required 0", bus.rd_valid); end
    n_checks++; if (bus.rd_data !== 8'h13) begin n_fail++; $display("FAIL nr_data_hold: got %h, required 13", bus.rd_data); end
    done();
    n_checks++; if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL nr_done_ignored: got %b, required 1", bus.rd_bank); end
  endtask

  task automatic test_early_close();
    do_reset();
    wr(8'hA0);
    wr(8'hA1);
    last_only();
    n_checks++; if (bus.bank_ready !== 1'b1) begin n_fail++; $display("FAIL ec_ready: got %b, required 1", bus.bank_ready); end
    n_checks++; if (bus.rd_len !== 3'd2) begin n_fail++; $display("FAIL ec_len: got %0d, required 2", bus.rd_len); end
    last_only();
    wr(8'hB0);
    last_only();
    rd(2'd0, 8'hA0);
    rd(2'd1, 8'hA1);
    rd(2'd2, 8'h12);
    done();
    n_checks++; if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL ec_bank1: got %b, required 1", bus.rd_bank); end
    n_checks++; if (bus.bank_ready !== 1'b1) begin n_fail++; $display("FAIL ec_ready1: got %b, required 1", bus.bank_ready); end
    n_checks++; if (bus.rd_len !== 3'd1) begin n_fail++; $display("FAIL ec_len1: got %0d, required 1", bus.rd_len); end
    rd(2'd0, 8'hB0);
    drain_check("early_close");
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ec_ovf: got %b, required 0", bus.overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'(8'h20 + i));
    n_checks++; if (bus.rd_len !== 3'd4) begin n_fail++; $display("FAIL ovf_len: got %0d, required 4", bus.rd_len); end
    wr(8'h30);
    cyc(1'b1, 8'h31, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00);
    wr(8'h32);
    n_checks++; if (bus.overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, required 1", bus.overflow); end
    n_checks++; if (bus.drop_cnt !== 16'd3) begin n_fail++; $display("FAIL ovf_cnt3: got %0d, required 3", bus.drop_cnt); end
    rd(2'd3, 8'h23);
    // Release and write to the same full bank in one cycle: write still dropped
    cyc(1'b1, 8'h3F, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 8'h00);
    n_checks++; if (bus.drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_cnt4: got %0d, required 4", bus.drop_cnt); end
    n_checks++; if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL ovf_bank: got %b, required 1", bus.rd_bank); end
    n_checks++; if (bus.rd_len !== 3'd4) begin n_fail++; $display("FAIL ovf_len1: got %0d, required 4", bus.rd_len); end
    wr(8'h40);
    n_checks++; if (bus.drop_cnt !== 16'd4) begin n_fail++; $display("FAIL ovf_accept: got %0d, required 4", bus.drop_cnt); end
    rd(2'd3, 8'h27);
    done();
    n_checks++; if (bus.bank_ready !== 1'b0) begin n_fail++; $display("FAIL ovf_b0_open: got %b, required 0", bus.bank_ready); end
    last_only();
    n_checks++; if (bus.rd_len !== 3'd1) begin n_fail++; $display("FAIL ovf_len0: got %0d, required 1", bus.rd_len); end
    rd(2'd0, 8'h40);
    drain_check("overflow");
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 4; i++) wr(8'(8'h50 + i));
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b1, 2'(i), 1'b0, 1'b1, 8'(8'h50 + i));
    cyc(1'b1, 8'h63, 1'b0, 1'b1, 2'd3, 1'b1, 1'b1, 8'h53);
    n_checks++; if (bus.rd_bank !== 1'b1) begin n_fail++; $display("FAIL b2b_bank: got %b, required 1", bus.rd_bank); end
    n_checks++; if (bus.bank_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready: got %b, required 1", bus.bank_ready); end
    n_checks++; if (bus.rd_len !== 3'd4) begin n_fail++; $display("FAIL b2b_len: got %0d, required 4", bus.rd_len); end
    rd(2'd3, 8'h63);
    rd(2'd0, 8'h60);
    done();
    n_checks++; if (bus.bank_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %b, required 0", bus.bank_ready); end
    drain_check("back_to_back");
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 8; i++) wr(8'(8'h70 + i));
    wr(8'h78);
    rd(2'd1, 8'h71);
    done();
    wr(8'h79);
    wr(8'h7A);
    drain_check("reset_mid_pre");
    do_reset();
    n_checks++; if (bus.bank_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ready: got %b, required 0", bus.bank_ready); end
    n_checks++; if (bus.rd_bank !== 1'b0) begin n_fail++; $display("FAIL rm_bank: got %b, required 0", bus.rd_bank); end
    n_checks++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL rm_ovf: got %b, required 0", bus.overflow); end
    n_checks++; if (bus.drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rm_drop: got %0d, required 0", bus.drop_cnt); end
    n_checks++; if (bus.rd_data !== 8'h00) begin n_fail++; $display("FAIL rm_data: got %h, required 00", bus.rd_data); end
    for (int i = 0; i < 3; i++) wr(8'(8'h80 + i));
    n_checks++; if (bus.bank_ready !== 1'b0) begin n_fail++; $display("FAIL rm_ptr: got %b, required 0", bus.bank_ready); end
    wr(8'h83);
    n_checks++; if (bus.rd_len !== 3'd4) begin n_fail++; $display("FAIL rm_len: got %0d, required 4", bus.rd_len); end
    rd(2'd0, 8'h80);
    drain_check("reset_mid");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 13; i++) begin
      bus2.wr_en = 1'b1; bus2.wr_data = 8'(8'h90 + i);
      tick();
      if (i >= 8) begin
        n_checks++;
        if (bus2.drop_cnt !== 2'((i - 7 > 3) ? 3 : i - 7)) begin
          n_fail++;
          $display("FAIL sat_cnt%0d: got %0d, required %0d", i - 7, bus2.drop_cnt, (i - 7 > 3) ? 3 : i - 7);
        end
      end
    end
    bus2.wr_en = 1'b0;
    n_checks++; if (bus2.overflow !== 1'b1) begin n_fail++; $display("FAIL sat_ovf: got %b, required 1", bus2.overflow); end
  endtask

  initial begin
    bus.wr_en = 1'b0; bus.wr_data = '0; bus.wr_last = 1'b0;
    bus.rd_en = 1'b0; bus.rd_addr = '0; bus.rd_done = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_data = '0; bus2.wr_last = 1'b0;
    bus2.rd_en = 1'b0; bus2.rd_addr = '0; bus2.rd_done = 1'b0;
    test_reset();
    test_fill_read();
    test_not_ready();
    test_early_close();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
